// File: rtl/regfile_mp.sv
// Multi-port general-purpose register file: two read ports, write-address readback,
// optional write-to-read bypass, hardware clear sweep and per-register pending bits.
module regfile_mp #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 4,
   parameter int DEPTH   = 16,
   parameter bit BYPASS  = 1'b1,
   parameter bit ZERO_R0 = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_wr_ad,
   input  logic [DATA_W-1:0] i_d,
   input  logic [ADDR_W-1:0] i_ra_ad,
   input  logic [ADDR_W-1:0] i_rb_ad,
   output logic [DATA_W-1:0] o_ra,
   output logic [DATA_W-1:0] o_rb,
   output logic [DATA_W-1:0] o_wr_o,
   input  logic              i_mark_we,
   input  logic [ADDR_W-1:0] i_mark_ad,
   output logic              o_pend_a,
   output logic              o_pend_b,
   output logic [DEPTH-1:0]  o_pend,
   output logic              o_ready
);

   localparam logic [0:0]        ST_CLEAR = 1'b0;
   localparam logic [0:0]        ST_READY = 1'b1;
   localparam logic [ADDR_W-1:0] LAST_AD  = ADDR_W'(DEPTH - 1);

   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_clr_cnt;
   logic [DEPTH-1:0]  r_pend;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_ready;
   logic              w_wr_ok;
   logic              w_mark_ok;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_ad;
   logic [DATA_W-1:0] w_mem_d;
   logic [DEPTH-1:0]  w_pend_nxt;

   function automatic logic writable(input logic [ADDR_W-1:0] ad);
      return !(ZERO_R0 && (ad == '0));
   endfunction

   assign w_ready   = (r_state == ST_READY);
   assign w_wr_ok   = w_ready && i_we && !i_clr && writable(i_wr_ad);
   assign w_mark_ok = w_ready && i_mark_we && !i_clr && writable(i_mark_ad);

   // Clear sweep walks every entry once; i_clr restarts it from entry 0.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= ST_CLEAR;
         r_clr_cnt <= '0;
      end else if (i_clr) begin
         r_state   <= ST_CLEAR;
         r_clr_cnt <= '0;
      end else if (!w_ready) begin
         if (r_clr_cnt == LAST_AD) begin
            r_state <= ST_READY;
         end
         r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
      end
   end

   // Single write port shared by the clear sweep and normal writeback.
   assign w_mem_we = !w_ready || w_wr_ok;
   assign w_mem_ad = w_ready ? i_wr_ad : r_clr_cnt;
   assign w_mem_d  = w_ready ? i_d : '0;

   always_ff @(posedge i_clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_ad] <= w_mem_d;
      end
   end

   always_comb begin
      w_pend_nxt = r_pend;
      if (w_wr_ok) begin
         w_pend_nxt[i_wr_ad] = 1'b0;
      end
      // Mark is applied after the write so it wins on an address collision.
      if (w_mark_ok) begin
         w_pend_nxt[i_mark_ad] = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pend <= '0;
      end else if (i_clr) begin
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_nxt;
      end
   end

   always_comb begin
      o_ra   = '0;
      o_rb   = '0;
      o_wr_o = '0;
      if (w_ready) begin
         if (writable(i_ra_ad)) begin
            o_ra = (BYPASS && i_we && (i_wr_ad == i_ra_ad)) ? i_d : r_mem[i_ra_ad];
         end
         if (writable(i_rb_ad)) begin
            o_rb = (BYPASS && i_we && (i_wr_ad == i_rb_ad)) ? i_d : r_mem[i_rb_ad];
         end
         if (writable(i_wr_ad)) begin
            o_wr_o = r_mem[i_wr_ad];
         end
      end
   end

   assign o_pend_a = w_ready && r_pend[i_ra_ad];
   assign o_pend_b = w_ready && r_pend[i_rb_ad];
   assign o_pend   = r_pend;
   assign o_ready  = w_ready;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp, run against a behavioural model
// with one bypassing and one non-bypassing instance driven by the same inputs.
module tb_regfile_mp;

   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst_n, clr, we, mark_we;
   logic [3:0]  wr_ad, ra_ad, rb_ad, mark_ad;
   logic [15:0] d;

   logic [15:0] ra, rb, wr_o, pend;
   logic        pend_a, pend_b, ready;
   logic [15:0] nb_ra, nb_rb, nb_wr_o, nb_pend;
   logic        nb_pend_a, nb_pend_b, nb_ready;

   int errors = 0;
   int checks = 0;

   int m_mem [N];
   bit m_pend [N];
   int m_left;

   always #5 clk = ~clk;

   regfile_mp #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_we(we), .i_wr_ad(wr_ad), .i_d(d),
      .i_ra_ad(ra_ad), .i_rb_ad(rb_ad), .o_ra(ra), .o_rb(rb), .o_wr_o(wr_o),
      .i_mark_we(mark_we), .i_mark_ad(mark_ad), .o_pend_a(pend_a), .o_pend_b(pend_b),
      .o_pend(pend), .o_ready(ready)
   );

   regfile_mp #(.DATA_W(16), .ADDR_W(4), .DEPTH(16), .BYPASS(1'b0), .ZERO_R0(1'b1)) dut_nb (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_we(we), .i_wr_ad(wr_ad), .i_d(d),
      .i_ra_ad(ra_ad), .i_rb_ad(rb_ad), .o_ra(nb_ra), .o_rb(nb_rb), .o_wr_o(nb_wr_o),
      .i_mark_we(mark_we), .i_mark_ad(mark_ad), .o_pend_a(nb_pend_a), .o_pend_b(nb_pend_b),
      .o_pend(nb_pend), .o_ready(nb_ready)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_rd(input int ad, input bit byp);
      if (m_left != 0) return 0;
      if (ad == 0) return 0;
      if (byp && we && (ad == int'(wr_ad))) return int'(d);
      return m_mem[ad];
   endfunction

   function automatic int exp_pvec();
      int v = 0;
      for (int i = 0; i < N; i++) if (m_pend[i]) v |= (1 << i);
      return v;
   endfunction

   task automatic model_reset();
      m_left = N;
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
   endtask

   // Applies the register-file rules for one rising edge using the current inputs.
   task automatic model_update();
      if (!rst_n) begin
         model_reset();
      end else if (m_left != 0) begin
         m_mem[N - m_left] = 0;
         m_left--;
         if (clr) m_left = N;
      end else if (clr) begin
         model_reset();
      end else begin
         if (we && wr_ad != 0) begin
            m_mem[wr_ad] = int'(d);
            m_pend[wr_ad] = 1'b0;
         end
         if (mark_we && mark_ad != 0) m_pend[mark_ad] = 1'b1;
      end
   endtask

   task automatic settle();
      int rdy;
      @(negedge clk);
      rdy = (m_left == 0) ? 1 : 0;
      chk("ready", ready, rdy);
      chk("nb_ready", nb_ready, rdy);
      chk("ra", ra, exp_rd(ra_ad, 1'b1));
      chk("rb", rb, exp_rd(rb_ad, 1'b1));
      chk("nb_ra", nb_ra, exp_rd(ra_ad, 1'b0));
      chk("nb_rb", nb_rb, exp_rd(rb_ad, 1'b0));
      chk("wr_o", wr_o, exp_rd(wr_ad, 1'b0));
      chk("nb_wr_o", nb_wr_o, exp_rd(wr_ad, 1'b0));
      chk("pend_a", pend_a, rdy ? int'(m_pend[ra_ad]) : 0);
      chk("pend_b", pend_b, rdy ? int'(m_pend[rb_ad]) : 0);
      chk("pend", pend, exp_pvec());
      chk("nb_pend", nb_pend, exp_pvec());
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step();
      settle();
      tick();
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (ready !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk(tag, n, 16);
   endtask

   task automatic idle();
      clr = 0; we = 0; mark_we = 0;
   endtask

   initial begin
      rst_n = 0; clr = 0; we = 0; mark_we = 0;
      wr_ad = 0; ra_ad = 0; rb_ad = 0; mark_ad = 0; d = 0;
      for (int i = 0; i < N; i++) m_mem[i] = 0;
      model_reset();
      #1;
      chk("rst_ready", ready, 0);
      chk("rst_pend", pend, 0);
      step();
      step();
      rst_n = 1;

      // 1: initial clear sweep, then every register reads zero
      wait_ready("t1_ready_lat");
      for (int a = 0; a < N; a++) begin
         ra_ad = 4'(a); rb_ad = 4'(N - 1 - a);
         settle();
         chk("t1_rd", ra, 0);
         tick();
      end

      // 2: write/readback on both ports, r0 hardwired to zero
      we = 1; wr_ad = 5; d = 16'hBEEF; step();
      we = 0; ra_ad = 5; rb_ad = 5;
      settle(); chk("t2_ra", ra, 16'hBEEF); chk("t2_rb", rb, 16'hBEEF); tick();
      we = 1; wr_ad = 0; d = 16'h1234; step();
      we = 0; ra_ad = 0; settle(); chk("t2_r0", ra, 0); tick();

      // 3: same-cycle bypass vs stored value
      we = 1; wr_ad = 7; d = 16'h1111; step();
      we = 1; wr_ad = 7; d = 16'hA5A5; ra_ad = 7;
      settle();
      chk("t3_byp", ra, 16'hA5A5);
      chk("t3_nobyp", nb_ra, 16'h1111);
      chk("t3_wr_o", wr_o, 16'h1111);
      tick();
      we = 0; settle(); chk("t3_after", nb_ra, 16'hA5A5); tick();

      // 4: pending mark, clear by write, mark wins on collision
      mark_we = 1; mark_ad = 3; step();
      mark_we = 0; ra_ad = 3;
      settle(); chk("t4_pend_a", pend_a, 1); chk("t4_pvec3", pend[3], 1); tick();
      we = 1; wr_ad = 3; d = 16'h0042;
      settle(); chk("t4_pend_hold", pend_a, 1); tick();
      we = 0; settle(); chk("t4_pend_clr", pend_a, 0); tick();
      we = 1; wr_ad = 4; d = 16'h0404; mark_we = 1; mark_ad = 4; step();
      idle(); ra_ad = 4;
      settle(); chk("t4_pend4", pend[4], 1); chk("t4_r4", ra, 16'h0404); tick();

      // 5: fill, then i_clr with writes/marks during the sweep
      for (int a = 1; a < N; a++) begin
         we = 1; wr_ad = 4'(a); d = 16'(16'h1000 + a); step();
      end
      clr = 1; we = 1; wr_ad = 9; d = 16'hFFFF; step();
      clr = 0; wr_ad = 3; d = 16'hDEAD; mark_we = 1; mark_ad = 6;
      wait_ready("t5_ready_lat");
      idle();
      chk("t5_pend", pend, 0);
      for (int a = 0; a < N; a++) begin
         ra_ad = 4'(a); settle(); chk("t5_rd", ra, 0); tick();
      end

      // 6: reset in the middle of the sweep restarts it
      clr = 1; step(); clr = 0;
      for (int i = 0; i < 7; i++) step();
      rst_n = 0; model_reset(); #1;
      chk("t6_rst_ready", ready, 0);
      step();
      rst_n = 1; mark_we = 1; mark_ad = 2;
      wait_ready("t6_ready_lat");
      idle();
      chk("t6_pend", pend, 0);

      // randomised traffic against the model
      for (int c = 0; c < 600; c++) begin
         we      = ($urandom_range(0, 1) == 1);
         wr_ad   = 4'($urandom_range(0, 15));
         d       = 16'($urandom);
         mark_we = ($urandom_range(0, 3) == 0);
         mark_ad = ($urandom_range(0, 3) == 0) ? wr_ad : 4'($urandom_range(0, 15));
         ra_ad   = ($urandom_range(0, 2) == 0) ? wr_ad : 4'($urandom_range(0, 15));
         rb_ad   = ($urandom_range(0, 3) == 0) ? ra_ad : 4'($urandom_range(0, 15));
         clr     = ($urandom_range(0, 99) == 0);
         step();
      end
      idle();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
